// File: rtl/uart8_transceiver.sv
// uart8_transceiver: 8N1 UART with fixed baud rate.
// The receiver oversamples the line and samples each bit in the middle.
// The transmitter shifts one bit per baud tick.
// The rx and tx paths share only the clock and reset, so full duplex works.
`timescale 1ns/1ps

module uart8_transceiver #(
  parameter int CLOCK_RATE    = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int RX_DIV   = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int TX_DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_DIV_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int SAMPLE_W = $clog2(RX_OVERSAMPLE);

  localparam logic [RX_DIV_W-1:0] RX_DIV_LAST = RX_DIV_W'(RX_DIV - 1);
  localparam logic [TX_DIV_W-1:0] TX_DIV_LAST = TX_DIV_W'(TX_DIV - 1);
  // The start bit is re-checked half a bit after the falling edge is seen.
  // That puts every later sample in the middle of its bit.
  localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(RX_OVERSAMPLE - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxStateT;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} txStateT;

  logic [RX_DIV_W-1:0] rxDivCntReg;
  logic [TX_DIV_W-1:0] txDivCntReg;
  logic                rxTick;
  logic                txTick;
  logic                rxMetaReg;
  logic                rxSyncReg;

  rxStateT             rxStateReg, rxStateNext;
  logic [SAMPLE_W-1:0] rxSampleReg, rxSampleNext;
  logic [2:0]          rxBitIdxReg, rxBitIdxNext;
  logic [7:0]          rxShiftReg, rxShiftNext;
  logic [7:0]          outReg, outNext;
  logic                rxDoneReg, rxDoneNext;
  logic                rxErrReg, rxErrNext;

  txStateT             txStateReg, txStateNext;
  logic [2:0]          txBitIdxReg, txBitIdxNext;
  logic [7:0]          txDataReg, txDataNext;
  logic                txLineReg, txLineNext;
  logic                txDoneReg, txDoneNext;

  assign rxTick = (rxDivCntReg == RX_DIV_LAST);
  assign txTick = (txDivCntReg == TX_DIV_LAST);

  // Free-running rx oversample divider, one-clock tick at wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rxDivCntReg <= '0;
    else if (rxTick)
      rxDivCntReg <= '0;
    else
      rxDivCntReg <= rxDivCntReg + RX_DIV_W'(1);
  end

  // Free-running tx bit-rate divider, one-clock tick at wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      txDivCntReg <= '0;
    else if (txTick)
      txDivCntReg <= '0;
    else
      txDivCntReg <= txDivCntReg + TX_DIV_W'(1);
  end

  // Two-flop synchronizer on rx.
  // An unknown level counts as high, so it can never fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMetaReg <= 1'b1;
      rxSyncReg <= 1'b1;
    end else begin
      rxMetaReg <= (rx !== 1'b0);
      rxSyncReg <= rxMetaReg;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxStateReg  <= RX_IDLE;
      rxSampleReg <= '0;
      rxBitIdxReg <= '0;
      rxShiftReg  <= '0;
      outReg      <= '0;
      rxDoneReg   <= 1'b0;
      rxErrReg    <= 1'b0;
    end else begin
      rxStateReg  <= rxStateNext;
      rxSampleReg <= rxSampleNext;
      rxBitIdxReg <= rxBitIdxNext;
      rxShiftReg  <= rxShiftNext;
      outReg      <= outNext;
      rxDoneReg   <= rxDoneNext;
      rxErrReg    <= rxErrNext;
    end
  end

  // Receiver next state: start detect, mid-bit sampling, stop-bit check.
  always_comb begin
    rxStateNext  = rxStateReg;
    rxSampleNext = rxSampleReg;
    rxBitIdxNext = rxBitIdxReg;
    rxShiftNext  = rxShiftReg;
    outNext      = outReg;
    rxDoneNext   = 1'b0;
    rxErrNext    = 1'b0;
    if (!rxEn) begin
      // Disabling the receiver drops any frame in progress without reporting it.
      rxStateNext  = RX_IDLE;
      rxSampleNext = '0;
      rxBitIdxNext = '0;
    end else if (rxTick) begin
      case (rxStateReg)
        RX_IDLE: begin
          if (!rxSyncReg) begin
            rxStateNext  = RX_START;
            rxSampleNext = '0;
          end
        end
        RX_START: begin
          if (rxSampleReg == HALF_LAST) begin
            rxSampleNext = '0;
            rxBitIdxNext = '0;
            if (!rxSyncReg) begin
              rxStateNext = RX_DATA;
            end else begin
              rxStateNext = RX_IDLE;
              rxErrNext   = 1'b1;
            end
          end else begin
            rxSampleNext = rxSampleReg + SAMPLE_W'(1);
          end
        end
        RX_DATA: begin
          if (rxSampleReg == FULL_LAST) begin
            rxSampleNext              = '0;
            rxShiftNext[rxBitIdxReg]  = rxSyncReg;
            if (rxBitIdxReg == 3'd7)
              rxStateNext = RX_STOP;
            else
              rxBitIdxNext = rxBitIdxReg + 3'd1;
          end else begin
            rxSampleNext = rxSampleReg + SAMPLE_W'(1);
          end
        end
        RX_STOP: begin
          if (rxSampleReg == FULL_LAST) begin
            rxSampleNext = '0;
            rxStateNext  = RX_IDLE;
            if (rxSyncReg) begin
              outNext    = rxShiftReg;
              rxDoneNext = 1'b1;
            end else begin
              rxErrNext  = 1'b1;
            end
          end else begin
            rxSampleNext = rxSampleReg + SAMPLE_W'(1);
          end
        end
        default: rxStateNext = RX_IDLE;
      endcase
    end
  end

  assign rxBusy = (rxStateReg != RX_IDLE);
  assign rxDone = rxDoneReg;
  assign rxErr  = rxErrReg;
  assign out    = outReg;

  // Transmitter state registers.
  // The line is registered so tx never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txStateReg  <= TX_IDLE;
      txBitIdxReg <= '0;
      txDataReg   <= '0;
      txLineReg   <= 1'b1;
      txDoneReg   <= 1'b0;
    end else begin
      txStateReg  <= txStateNext;
      txBitIdxReg <= txBitIdxNext;
      txDataReg   <= txDataNext;
      txLineReg   <= txLineNext;
      txDoneReg   <= txDoneNext;
    end
  end

  // Transmitter next state.
  // A frame is accepted at any clock, then aligned to the next bit tick in LOAD.
  always_comb begin
    txStateNext  = txStateReg;
    txBitIdxNext = txBitIdxReg;
    txDataNext   = txDataReg;
    txDoneNext   = 1'b0;
    case (txStateReg)
      TX_IDLE: begin
        if (txEn && txStart) begin
          txDataNext  = in;
          txStateNext = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (txTick)
          txStateNext = TX_START;
      end
      TX_START: begin
        if (txTick) begin
          txStateNext  = TX_DATA;
          txBitIdxNext = '0;
        end
      end
      TX_DATA: begin
        if (txTick) begin
          if (txBitIdxReg == 3'd7)
            txStateNext = TX_STOP;
          else
            txBitIdxNext = txBitIdxReg + 3'd1;
        end
      end
      TX_STOP: begin
        if (txTick) begin
          txStateNext = TX_IDLE;
          txDoneNext  = 1'b1;
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
    case (txStateNext)
      TX_START: txLineNext = 1'b0;
      TX_DATA:  txLineNext = txDataReg[txBitIdxNext];
      default:  txLineNext = 1'b1;
    endcase
  end

  assign txBusy = (txStateReg != TX_IDLE);
  assign txDone = txDoneReg;
  assign tx     = txLineReg;

endmodule

// File: tb/tb_uart8_transceiver.sv
// tb_uart8_transceiver: directed and randomized checks of the 8N1 transceiver at default rates.
// Time is counted in clocks: one bit is 1250 clocks at the nominal rate.
`timescale 1ns/1ps

module tb_uart8_transceiver;

  localparam int BIT_CLKS = 1250;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxEn = 1'b0;
  logic       rxDrive = 1'b1;
  logic       loopBack = 1'b0;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] inByte = 8'h00;
  logic       rxLine;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, txLine;
  logic [7:0] dataOut;

  int checks = 0;
  int errors = 0;
  int rxDoneCnt = 0;
  int rxErrCnt = 0;
  int txDoneCnt = 0;
  int txLowCnt = 0;

  assign rxLine = loopBack ? txLine : rxDrive;

  uart8_transceiver dut (
    .clk(clk), .rst(rst),
    .rxEn(rxEn), .rx(rxLine), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .out(dataOut),
    .txEn(txEn), .txStart(txStart), .in(inByte), .txBusy(txBusy), .txDone(txDone), .tx(txLine)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Count strobes and low tx cycles so that steps can compare before/after deltas.
  always @(posedge clk) begin
    if (rxDone === 1'b1) rxDoneCnt <= rxDoneCnt + 1;
    if (rxErr === 1'b1)  rxErrCnt  <= rxErrCnt + 1;
    if (txDone === 1'b1) txDoneCnt <= txDoneCnt + 1;
    if (txLine === 1'b0) txLowCnt  <= txLowCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic waitClks(input int n);
    repeat (n) stepClk();
  endtask

  // Reference framing: start 0, eight data bits LSB first, then the stop bit.
  function automatic logic [9:0] frameOf(input logic [7:0] d, input logic stopBit);
    return {stopBit, d, 1'b0};
  endfunction

  // Drive one serial frame on rx.
  // Optionally confirm rxBusy in the middle of the start and data bits.
  task automatic driveFrame(input logic [7:0] d, input logic stopBit, input int bitClks,
                            input logic checkBusy);
    logic [9:0] f;
    f = frameOf(d, stopBit);
    for (int k = 0; k < 10; k++) begin
      rxDrive = f[k];
      for (int c = 0; c < bitClks; c++) begin
        stepClk();
        if (checkBusy && k < 9 && c == bitClks / 2)
          check($sformatf("rxBusy_bit%0d", k), rxBusy, 1'b1);
      end
    end
    rxDrive = 1'b1;
  endtask

  // Watch tx for one frame.
  // Checks each bit at mid-bit and that txDone lands exactly ten bit times after the start edge.
  task automatic checkTxFrame(input logic [7:0] d);
    logic [9:0] f;
    int n;
    int step;
    f = frameOf(d, 1'b1);
    n = 0;
    while (txLine !== 1'b0 && n < 2 * BIT_CLKS) begin
      stepClk();
      n++;
    end
    check("tx_start_seen", 32'(txLine === 1'b0), 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step = (k == 0) ? BIT_CLKS / 2 : BIT_CLKS;
      waitClks(step);
      n += step;
      check($sformatf("tx_bit%0d", k), txLine, f[k]);
      if (k == 0) check("txBusy_frame", txBusy, 1'b1);
    end
    while (txDone !== 1'b1 && n < 11 * BIT_CLKS) begin
      stepClk();
      n++;
    end
    check("txDone_clks", n, 10 * BIT_CLKS);
    check("txBusy_end", txBusy, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_tx"}, txLine, 1'b1);
    check({tag, "_rxBusy"}, rxBusy, 1'b0);
    check({tag, "_rxDone"}, rxDone, 1'b0);
    check({tag, "_rxErr"}, rxErr, 1'b0);
    check({tag, "_out"}, dataOut, 8'h00);
    check({tag, "_txBusy"}, txBusy, 1'b0);
    check({tag, "_txDone"}, txDone, 1'b0);
  endtask

  initial begin
    logic [7:0] expOut;
    logic [7:0] rnd;
    logic [7:0] loopVals [2];
    int d0, e0, t0, l0, rate;
    loopVals[0] = 8'h00;
    loopVals[1] = 8'hFF;
    expOut = 8'h00;

    // Reset held, then released into idle.
    waitClks(3);
    checkResetValues("in_reset");
    rst = 1'b0;
    waitClks(20);
    checkResetValues("after_reset");
    $display("reset: tx=%0b out=%02h", txLine, dataOut);
    rxEn = 1'b1;
    waitClks(200);

    // Receive 0x35 from a sender about 3% slow.
    d0 = rxDoneCnt; e0 = rxErrCnt;
    driveFrame(8'h35, 1'b1, 1290, 1'b1);
    waitClks(300);
    expOut = 8'h35;
    check("slow35_out", dataOut, expOut);
    check("slow35_done", rxDoneCnt - d0, 1);
    check("slow35_err", rxErrCnt - e0, 0);
    check("slow35_busyEnd", rxBusy, 1'b0);
    $display("rx frame 35 @1290 clks/bit: out=%02h", dataOut);

    // Full duplex: send 0xA5 while a random byte arrives at a random rate within 3%.
    rnd = 8'($urandom_range(0, 255));
    if (rnd == 8'h35) rnd = 8'hCA;
    rate = $urandom_range(1213, 1287);
    txEn = 1'b1;
    inByte = 8'hA5;
    d0 = rxDoneCnt; e0 = rxErrCnt; t0 = txDoneCnt;
    txStart = 1'b1;
    stepClk();
    txStart = 1'b0;
    fork
      checkTxFrame(8'hA5);
      driveFrame(rnd, 1'b1, rate, 1'b0);
    join
    waitClks(300);
    expOut = rnd;
    check("duplex_out", dataOut, expOut);
    check("duplex_rxDone", rxDoneCnt - d0, 1);
    check("duplex_rxErr", rxErrCnt - e0, 0);
    check("duplex_txDone", txDoneCnt - t0, 1);
    $display("duplex: tx A5, rx %02h @%0d clks/bit, out=%02h", rnd, rate, dataOut);

    // Stop bit driven low: framing error, byte discarded.
    // The low line may re-trigger start detection, so at least one rxErr is expected.
    d0 = rxDoneCnt; e0 = rxErrCnt;
    driveFrame(8'h35, 1'b0, BIT_CLKS, 1'b0);
    waitClks(1500);
    check("badStop_err", 32'((rxErrCnt - e0) >= 1), 1);
    check("badStop_done", rxDoneCnt - d0, 0);
    check("badStop_out", dataOut, expOut);
    $display("rx frame 35 bad stop: out=%02h errs=%0d", dataOut, rxErrCnt - e0);

    // Start glitch of two rx ticks.
    d0 = rxDoneCnt; e0 = rxErrCnt;
    rxDrive = 1'b0;
    waitClks(156);
    rxDrive = 1'b1;
    waitClks(1200);
    check("glitch_err", rxErrCnt - e0, 1);
    check("glitch_done", rxDoneCnt - d0, 0);
    check("glitch_out", dataOut, expOut);
    check("glitch_busy", rxBusy, 1'b0);
    $display("rx glitch: errs=%0d out=%02h", rxErrCnt - e0, dataOut);

    // Transmitter disabled: txStart is ignored.
    txEn = 1'b0;
    inByte = 8'h5A;
    txStart = 1'b1;
    l0 = txLowCnt;
    waitClks(3000);
    check("txOff_low", txLowCnt - l0, 0);
    check("txOff_busy", txBusy, 1'b0);
    txStart = 1'b0;
    txEn = 1'b1;
    $display("tx disabled: low cycles=%0d", txLowCnt - l0);

    // Loop tx back into rx with all-zero and all-one bytes.
    loopBack = 1'b1;
    waitClks(50);
    for (int i = 0; i < 2; i++) begin
      d0 = rxDoneCnt; e0 = rxErrCnt; t0 = txDoneCnt;
      inByte = loopVals[i];
      txStart = 1'b1;
      stepClk();
      txStart = 1'b0;
      checkTxFrame(loopVals[i]);
      waitClks(100);
      expOut = loopVals[i];
      check($sformatf("loop%02h_out", loopVals[i]), dataOut, expOut);
      check($sformatf("loop%02h_rxDone", loopVals[i]), rxDoneCnt - d0, 1);
      check($sformatf("loop%02h_rxErr", loopVals[i]), rxErrCnt - e0, 0);
      check($sformatf("loop%02h_txDone", loopVals[i]), txDoneCnt - t0, 1);
      $display("loopback %02h: out=%02h", loopVals[i], dataOut);
    end

    // Reset in the middle of a looped frame: outputs return at once, before any clock edge.
    inByte = 8'($urandom_range(0, 255));
    txStart = 1'b1;
    stepClk();
    txStart = 1'b0;
    waitClks(5000);
    check("midFrame_txBusy", txBusy, 1'b1);
    check("midFrame_rxBusy", rxBusy, 1'b1);
    rst = 1'b1;
    #2;
    checkResetValues("async_reset");
    waitClks(3);
    rst = 1'b0;
    expOut = 8'h00;
    d0 = rxDoneCnt; e0 = rxErrCnt;
    waitClks(3000);
    check("postReset_tx", txLine, 1'b1);
    check("postReset_out", dataOut, expOut);
    check("postReset_rxDone", rxDoneCnt - d0, 0);
    check("postReset_rxErr", rxErrCnt - e0, 0);
    check("postReset_txBusy", txBusy, 1'b0);
    $display("reset mid-frame (byte %02h): tx=%0b out=%02h", inByte, txLine, dataOut);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
